// File: rtl/hit_arbiter.sv
// Timestamps rising-edge hits per channel and serializes them through a round-robin valid/ready port.
// Optional HIT_LOST_COUNT_EN builds the saturating dropped-hit counter; otherwise lost_cnt reads 0.
module hit_arbiter #(
  parameter int N_CH = 4,
  parameter int TS_W = 32,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [N_CH-1:0] ch_in,
  input  logic            enable,
  input  logic            lost_clr,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [CH_W-1:0] ev_ch,
  output logic [TS_W-1:0] ev_ts,
  output logic [N_CH-1:0] lost_flags,
  output logic [15:0]     lost_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t          state, state_next;
  logic [N_CH-1:0] s1, s2, hit_edge, pending, grant_vec, loss;
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_slot [N_CH];
  logic [CH_W-1:0] rr_ptr, grant_idx;
  logic            grant;

  assign hit_edge = s1 & ~s2 & {N_CH{enable}};
  // A slot being granted this cycle is free for a new edge, so that is not a loss.
  assign loss     = hit_edge & pending & ~grant_vec;
  assign ev_valid = (state == PRESENT);

  always_comb begin
    logic [CH_W-1:0] idx;
    idx       = '0;
    grant     = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    if (state == IDLE) begin
      for (int k = 0; k < N_CH; k++) begin
        idx = CH_W'((int'(rr_ptr) + k) % N_CH);
        if (!grant && pending[idx]) begin
          grant     = 1'b1;
          grant_idx = idx;
        end
      end
    end
    if (grant) grant_vec[grant_idx] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = PRESENT;
      PRESENT: if (ev_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s1         <= '0;
      s2         <= '0;
      ts_cnt     <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      ev_ch      <= '0;
      ev_ts      <= '0;
      lost_flags <= '0;
      for (int i = 0; i < N_CH; i++) ts_slot[i] <= '0;
    end else begin
      s1         <= ch_in;
      s2         <= s1;
      ts_cnt     <= ts_cnt + 1'b1;
      pending    <= (pending & ~grant_vec) | hit_edge;
      lost_flags <= (lost_clr ? '0 : lost_flags) | loss;
      for (int i = 0; i < N_CH; i++) begin
        if (hit_edge[i] && !loss[i]) ts_slot[i] <= ts_cnt;
      end
      if (grant) begin
        ev_ch  <= grant_idx;
        ev_ts  <= ts_slot[grant_idx];
        rr_ptr <= (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + 1'b1;
      end
    end
  end

`ifdef HIT_LOST_COUNT_EN
  localparam int LN_W = $clog2(N_CH + 1);

  logic [LN_W-1:0] loss_num;
  logic [16:0]     cnt_sum;
  logic [15:0]     lost_cnt_r;

  always_comb begin
    loss_num = '0;
    for (int i = 0; i < N_CH; i++) loss_num = loss_num + LN_W'(loss[i]);
  end

  assign cnt_sum = (lost_clr ? 17'd0 : {1'b0, lost_cnt_r}) + 17'(loss_num);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) lost_cnt_r <= '0;
    else          lost_cnt_r <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  assign lost_cnt = lost_cnt_r;
`else
  assign lost_cnt = '0;
`endif

endmodule

// File: tb/tb_hit_arbiter.sv
// Scoreboard bench for hit_arbiter: expected events are queued at stimulus time and checked at handshake.
module tb_hit_arbiter;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  ch_in = '0;
  logic        enable = 1'b1;
  logic        lost_clr = 1'b0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [1:0]  ev_ch;
  logic [31:0] ev_ts;
  logic [3:0]  lost_flags;
  logic [15:0] lost_cnt;

`ifdef HIT_LOST_COUNT_EN
  localparam logic [15:0] ONE_LOSS = 16'd1;
`else
  localparam logic [15:0] ONE_LOSS = 16'd0;
`endif

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] ts;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] hs_q[$];
  logic [31:0] tb_ts;
  int          total = 0;
  int          bad = 0;

  hit_arbiter #(.N_CH(4), .TS_W(32)) dut (
    .clk(clk), .aresetn(aresetn), .ch_in(ch_in), .enable(enable), .lost_clr(lost_clr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_ts(ev_ts),
    .lost_flags(lost_flags), .lost_cnt(lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: the timestamp value visible during each clock cycle.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) tb_ts <= '0;
    else          tb_ts <= tb_ts + 32'd1;
  end

  task automatic push_exp(input logic [1:0] ch, input logic [31:0] ts);
    exp_t e;
    e.ch = ch;
    e.ts = ts;
    exp_q.push_back(e);
  endtask

  // One clock: check any handshake at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (aresetn && ev_valid && ev_ready) begin
      hs_q.push_back(tb_ts);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event got ch=%0d ts=%0d required no event", ev_ch, ev_ts);
      end else begin
        e = exp_q.pop_front();
        if (ev_ch !== e.ch || ev_ts !== e.ts) begin
          bad++;
          $display("FAIL event got ch=%0d ts=%0d required ch=%0d ts=%0d", ev_ch, ev_ts, e.ch, e.ts);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got %0d events outstanding required 0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic apply_reset();
    aresetn  = 1'b0;
    ch_in    = '0;
    ev_ready = 1'b0;
    enable   = 1'b1;
    lost_clr = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL reset_ev_valid got %0b required 0", ev_valid); end
    total++; if (ev_ch !== 2'd0) begin bad++; $display("FAIL reset_ev_ch got %0d required 0", ev_ch); end
    total++; if (ev_ts !== 32'd0) begin bad++; $display("FAIL reset_ev_ts got %0d required 0", ev_ts); end
    total++; if (lost_flags !== 4'd0) begin bad++; $display("FAIL reset_lost_flags got %b required 0000", lost_flags); end
    total++; if (lost_cnt !== 16'd0) begin bad++; $display("FAIL reset_lost_cnt got %0d required 0", lost_cnt); end
  endtask

  task automatic test_single();
    logic exp_valid [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    ev_ready = 1'b1;
    push_exp(2'd2, tb_ts + 32'd1);
    ch_in[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (ev_valid !== exp_valid[i]) begin
        bad++;
        $display("FAIL single_latency cycle %0d got ev_valid=%0b required %0b", i, ev_valid, exp_valid[i]);
      end
    end
    ch_in = '0;
    drain();
  endtask

  task automatic test_round_robin();
    logic [31:0] t;
    apply_reset();
    ev_ready = 1'b1;
    step();
    t = tb_ts + 32'd1;
    for (int c = 0; c < 4; c++) push_exp(2'(c), t);
    hs_q.delete();
    ch_in = 4'hF;
    drain();
    total++;
    if (hs_q.size() != 4) begin
      bad++;
      $display("FAIL rr_event_count got %0d required 4", hs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (hs_q[i+1] - hs_q[i] !== 32'd2) begin
          bad++;
          $display("FAIL rr_spacing got %0d required 2", hs_q[i+1] - hs_q[i]);
        end
      end
    end
    ch_in = '0;
    repeat (3) step();
    t = tb_ts + 32'd1;
    push_exp(2'd0, t);
    push_exp(2'd1, t);
    ch_in = 4'b0011;
    drain();
    ch_in = '0;
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] ts1;
    ev_ready = 1'b0;
    ts1 = '0;
    repeat (2) step();
    for (int p = 0; p < 3; p++) begin
      if (p == 0) ts1 = tb_ts + 32'd1;
      if (p < 2) push_exp(2'd1, tb_ts + 32'd1);
      ch_in[1] = 1'b1;
      step();
      ch_in[1] = 1'b0;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (ev_valid !== 1'b1 || ev_ch !== 2'd1 || ev_ts !== ts1) begin
        bad++;
        $display("FAIL bp_hold got valid=%0b ch=%0d ts=%0d required valid=1 ch=1 ts=%0d",
                 ev_valid, ev_ch, ev_ts, ts1);
      end
      step();
    end
    total++; if (lost_flags !== 4'b0010) begin bad++; $display("FAIL bp_lost_flags got %b required 0010", lost_flags); end
    total++; if (lost_cnt !== ONE_LOSS) begin bad++; $display("FAIL bp_lost_cnt got %0d required %0d", lost_cnt, ONE_LOSS); end
    ev_ready = 1'b1;
    drain();
    total++; if (lost_cnt !== ONE_LOSS) begin bad++; $display("FAIL bp_lost_cnt_after got %0d required %0d", lost_cnt, ONE_LOSS); end
  endtask

  task automatic test_lost_clr();
    ev_ready = 1'b0;
    step();
    for (int p = 0; p < 2; p++) begin
      push_exp(2'd0, tb_ts + 32'd1);
      ch_in[0] = 1'b1;
      step();
      ch_in[0] = 1'b0;
      step();
    end
    ch_in[0] = 1'b1;
    step();
    ch_in[0] = 1'b0;
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    total++; if (lost_flags !== 4'b0001) begin bad++; $display("FAIL clr_overrun_flags got %b required 0001", lost_flags); end
    total++; if (lost_cnt !== ONE_LOSS) begin bad++; $display("FAIL clr_overrun_cnt got %0d required %0d", lost_cnt, ONE_LOSS); end
    ev_ready = 1'b1;
    drain();
    lost_clr = 1'b1;
    step();
    lost_clr = 1'b0;
    total++; if (lost_flags !== 4'b0000) begin bad++; $display("FAIL clr_flags got %b required 0000", lost_flags); end
    total++; if (lost_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt got %0d required 0", lost_cnt); end
  endtask

  task automatic test_enable();
    ev_ready = 1'b1;
    step();
    push_exp(2'd3, tb_ts + 32'd1);
    ch_in[3] = 1'b1;
    step();
    step();
    enable = 1'b0;
    drain();
    ch_in = '0;
    repeat (2) step();
    ch_in = 4'hF;
    repeat (6) step();
    ch_in = '0;
    repeat (3) step();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL en_valid got %0b required 0", ev_valid); end
    total++; if (lost_flags !== 4'd0) begin bad++; $display("FAIL en_lost_flags got %b required 0000", lost_flags); end
    total++; if (lost_cnt !== 16'd0) begin bad++; $display("FAIL en_lost_cnt got %0d required 0", lost_cnt); end
    enable = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    ev_ready = 1'b0;
    ch_in = '0;
    repeat (2) step();
    ch_in = 4'hF;
    step();
    ch_in = '0;
    repeat (4) step();
    total++; if (ev_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got %0b required 1", ev_valid); end
    #2 aresetn = 1'b0;
    #1;
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got %0b required 0", ev_valid); end
    total++; if (ev_ts !== 32'd0) begin bad++; $display("FAIL mid_async_ts got %0d required 0", ev_ts); end
    exp_q.delete();
    @(posedge clk);
    #1 aresetn = 1'b1;
    ev_ready = 1'b1;
    repeat (8) step();
    total++; if (ev_valid !== 1'b0) begin bad++; $display("FAIL mid_after_valid got %0b required 0", ev_valid); end
    push_exp(2'd1, tb_ts + 32'd1);
    ch_in[1] = 1'b1;
    drain();
    ch_in = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lost_clr();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
